// File: rtl/ahb_resp_mux_wdt.sv
// AHB slave-to-master response multiplexer with built-in default slave
// and a per-transfer wait-state watchdog.
module ahb_resp_mux_wdt #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] DEFAULT_RDATA  = 32'hDEADBEEF,
  parameter int unsigned SEL_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             Hclk,
  input  logic                             Hreset,
  input  logic [NUM_SLAVES-1:0]            Hsel_dec,
  input  logic [1:0]                       Htrans,
  input  logic [DATA_WIDTH*NUM_SLAVES-1:0] Hrdata_S,
  input  logic [2*NUM_SLAVES-1:0]          Hresp_S,
  input  logic [NUM_SLAVES-1:0]            Hreadyout_S,
  output logic [DATA_WIDTH-1:0]            Hrdata,
  output logic [1:0]                       Hresp,
  output logic                             Hready,
  output logic                             err_unmapped,
  output logic                             err_timeout,
  output logic [SEL_W-1:0]                 timeout_slave
);

  localparam int unsigned WC_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT_CYCLES);
  localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT_CYCLES > 0) ? WC_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DATA_WIDTH-1:0] DEF_RD = DATA_WIDTH'(DEFAULT_RDATA);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ROUTE, ERR1, ERR2} state_t;

  state_t                  state, state_d;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    active_q;
  logic                    bad_q;
  logic [WC_W-1:0]         wait_cnt;

  logic                    sel_q_onehot;
  logic                    route_ok;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_resp;
  logic                    r_ready;
  logic                    cap_bad;
  logic                    unm_go;
  logic                    stall;
  logic                    wdt_fire;

  function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  function automatic logic [SEL_W-1:0] enc(input logic [NUM_SLAVES-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (v[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

  assign sel_q_onehot = is_onehot(sel_q);
  assign route_ok     = sel_q_onehot & ~bad_q;
  assign cap_bad      = Htrans[1] & ~is_onehot(Hsel_dec);
  assign unm_go       = Hready & cap_bad;

  always_comb begin
    r_rdata = '0;
    r_resp  = '0;
    r_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        r_rdata = r_rdata | Hrdata_S[i*DATA_WIDTH +: DATA_WIDTH];
        r_resp  = r_resp  | Hresp_S[i*2 +: 2];
        r_ready = r_ready | Hreadyout_S[i];
      end
    end
  end

  assign stall    = (state == ROUTE) & route_ok & active_q & ~r_ready;
  assign wdt_fire = (TIMEOUT_CYCLES != 0) & stall & (wait_cnt == WC_LAST);

  always_comb begin
    Hrdata = DEF_RD;
    Hresp  = RESP_OKAY;
    Hready = 1'b1;
    case (state)
      ROUTE: begin
        if (route_ok) begin
          Hrdata = r_rdata;
          Hresp  = r_resp;
          Hready = r_ready;
        end
      end
      ERR1: begin
        Hresp  = RESP_ERROR;
        Hready = 1'b0;
      end
      ERR2: begin
        Hresp  = RESP_ERROR;
      end
      default: ;
    endcase
  end

  // An unmapped transfer captured in ERR2 must enter ERR1 directly, so its
  // data phase never shows an OKAY cycle.
  always_comb begin
    state_d = state;
    case (state)
      ROUTE:   if (wdt_fire || unm_go) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = unm_go ? ERR1 : ROUTE;
      default: state_d = ROUTE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state         <= ROUTE;
      sel_q         <= '0;
      active_q      <= 1'b0;
      bad_q         <= 1'b0;
      wait_cnt      <= '0;
      timeout_slave <= '0;
      err_unmapped  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state        <= state_d;
      err_unmapped <= unm_go;
      err_timeout  <= wdt_fire;
      if (Hready) begin
        active_q <= Htrans[1];
        sel_q    <= Hsel_dec;
        bad_q    <= cap_bad;
      end
      if (state != ROUTE || Hready) begin
        wait_cnt <= '0;
      end else if (stall && wait_cnt != WC_MAX) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
      if (wdt_fire) timeout_slave <= enc(sel_q);
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux_wdt.sv
// Scoreboard bench for ahb_resp_mux_wdt: a watchdog-enabled instance (16)
// and a watchdog-disabled instance (0) share all inputs.
module tb_ahb_resp_mux_wdt;

  localparam logic [31:0] DEF  = 32'hDEADBEEF;
  localparam logic [31:0] S0   = 32'hA5A5_0000;
  localparam logic [31:0] S1   = 32'hA5A5_0001;
  localparam logic [31:0] S2   = 32'hA5A5_0002;
  localparam logic [31:0] S3   = 32'hA5A5_0003;
  localparam logic [1:0]  IDLE = 2'b00;
  localparam logic [1:0]  BUSY = 2'b01;
  localparam logic [1:0]  NSEQ = 2'b10;
  localparam logic [3:0]  ALL  = 4'b1111;

  logic         Hclk = 1'b0;
  logic         Hreset;
  logic [3:0]   Hsel_dec;
  logic [1:0]   Htrans;
  logic [127:0] Hrdata_S;
  logic [7:0]   Hresp_S;
  logic [3:0]   Hreadyout_S;

  logic [31:0]  Hrdata;
  logic [1:0]   Hresp;
  logic         Hready;
  logic         err_unmapped;
  logic         err_timeout;
  logic [1:0]   timeout_slave;

  logic [31:0]  Hrdata2;
  logic [1:0]   Hresp2;
  logic         Hready2;
  logic         err_unmapped2;
  logic         err_timeout2;
  logic [1:0]   timeout_slave2;

  always #5 Hclk = ~Hclk;

  ahb_resp_mux_wdt #(.NUM_SLAVES(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16),
                     .DEFAULT_RDATA(32'hDEADBEEF)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hsel_dec(Hsel_dec), .Htrans(Htrans),
    .Hrdata_S(Hrdata_S), .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hready(Hready),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout),
    .timeout_slave(timeout_slave)
  );

  ahb_resp_mux_wdt #(.NUM_SLAVES(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0),
                     .DEFAULT_RDATA(32'hDEADBEEF)) dut_nowdt (
    .Hclk(Hclk), .Hreset(Hreset), .Hsel_dec(Hsel_dec), .Htrans(Htrans),
    .Hrdata_S(Hrdata_S), .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S),
    .Hrdata(Hrdata2), .Hresp(Hresp2), .Hready(Hready2),
    .err_unmapped(err_unmapped2), .err_timeout(err_timeout2),
    .timeout_slave(timeout_slave2)
  );

  typedef struct {
    bit        c1;
    bit        rdy;
    bit [1:0]  resp;
    bit [31:0] rd;
    bit        eu;
    bit        et;
    bit [1:0]  ts;
    bit        c2;
    bit        rdy2;
    string     nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // One bus cycle: drive inputs just after the edge and queue what both
  // instances must show during this cycle.
  task automatic step(input bit rst, input logic [1:0] tr, input logic [3:0] sel,
                      input logic [3:0] srdy, input string nm,
                      input bit c1, input bit rdy, input bit [1:0] resp,
                      input bit [31:0] rd, input bit eu, input bit et,
                      input bit [1:0] ts, input bit c2, input bit rdy2);
    exp_t e;
    @(posedge Hclk);
    #1;
    Hreset      = rst;
    Htrans      = tr;
    Hsel_dec    = sel;
    Hreadyout_S = srdy;
    e.c1 = c1; e.rdy = rdy; e.resp = resp; e.rd = rd; e.eu = eu; e.et = et;
    e.ts = ts; e.c2 = c2; e.rdy2 = rdy2; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic dflt(input logic [1:0] tr, input logic [3:0] sel,
                      input bit [1:0] ts, input string nm);
    step(1'b0, tr, sel, ALL, nm, 1'b1, 1'b1, 2'b00, DEF, 1'b0, 1'b0, ts, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Hclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.c1) begin
          checks++;
          if (Hready !== e.rdy || Hresp !== e.resp || Hrdata !== e.rd ||
              err_unmapped !== e.eu || err_timeout !== e.et || timeout_slave !== e.ts) begin
            failures++;
            $display("FAIL %s: got rdy=%b resp=%b rdata=%h eu=%b et=%b ts=%0d, expected rdy=%b resp=%b rdata=%h eu=%b et=%b ts=%0d",
                     e.nm, Hready, Hresp, Hrdata, err_unmapped, err_timeout, timeout_slave,
                     e.rdy, e.resp, e.rd, e.eu, e.et, e.ts);
          end
        end
        if (e.c2) begin
          checks++;
          if (Hready2 !== e.rdy2 || err_timeout2 !== 1'b0) begin
            failures++;
            $display("FAIL %s(nowdt): got rdy=%b et=%b, expected rdy=%b et=0",
                     e.nm, Hready2, err_timeout2, e.rdy2);
          end
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL sim_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    Hreset      = 1'b1;
    Htrans      = IDLE;
    Hsel_dec    = '0;
    Hreadyout_S = ALL;
    Hrdata_S    = {S3, S2, S1, S0};
    Hresp_S     = '0;

    step(1'b1, IDLE, 4'b0000, ALL, "reset", 1, 1, 2'b00, DEF, 0, 0, 2'd0, 1, 1);
    dflt(IDLE, 4'b0000, 2'd0, "rst_rel");

    // zero-wait read from slave 2
    dflt(NSEQ, 4'b0100, 2'd0, "s2_addr");
    step(1'b0, IDLE, 4'b0000, ALL, "s2_data", 1, 1, 2'b00, S2, 0, 0, 2'd0, 1, 1);

    // slave 1 inserts three wait states
    dflt(NSEQ, 4'b0010, 2'd0, "s1_addr");
    repeat (3) step(1'b0, IDLE, 4'b0000, 4'b1101, "s1_wait", 1, 0, 2'b00, S1, 0, 0, 2'd0, 1, 0);
    step(1'b0, IDLE, 4'b0000, ALL, "s1_done", 1, 1, 2'b00, S1, 0, 0, 2'd0, 1, 1);

    // unmapped (no select), then a normal transfer issued in ERR2
    dflt(NSEQ, 4'b0000, 2'd0, "unm_addr");
    step(1'b0, IDLE, 4'b0000, ALL, "unm_err1", 1, 0, 2'b01, DEF, 1, 0, 2'd0, 1, 0);
    step(1'b0, NSEQ, 4'b0001, ALL, "unm_err2", 1, 1, 2'b01, DEF, 0, 0, 2'd0, 1, 1);
    step(1'b0, IDLE, 4'b0000, ALL, "unm_next", 1, 1, 2'b00, S0, 0, 0, 2'd0, 1, 1);

    // multi-hot select
    dflt(NSEQ, 4'b0110, 2'd0, "mh_addr");
    step(1'b0, IDLE, 4'b0000, ALL, "mh_err1", 1, 0, 2'b01, DEF, 1, 0, 2'd0, 1, 0);
    step(1'b0, NSEQ, 4'b1000, ALL, "mh_err2", 1, 1, 2'b01, DEF, 0, 0, 2'd0, 1, 1);
    step(1'b0, IDLE, 4'b0000, ALL, "mh_next", 1, 1, 2'b00, S3, 0, 0, 2'd0, 1, 1);

    // IDLE/BUSY to unmapped or multi-hot completes with zero wait, no error
    dflt(IDLE, 4'b0000, 2'd0, "idle_unm");
    dflt(BUSY, 4'b0110, 2'd0, "idle_dat");
    dflt(IDLE, 4'b0000, 2'd0, "busy_dat");

    // slave 3 releases on the last allowed wait cycle
    dflt(NSEQ, 4'b1000, 2'd0, "s3_addr");
    repeat (15) step(1'b0, IDLE, 4'b0000, 4'b0111, "s3_wait", 1, 0, 2'b00, S3, 0, 0, 2'd0, 1, 0);
    step(1'b0, IDLE, 4'b0000, ALL, "s3_last", 1, 1, 2'b00, S3, 0, 0, 2'd0, 1, 1);
    dflt(IDLE, 4'b0000, 2'd0, "s3_after");

    // slave 3 stalls: 16 wait cycles then ERROR; late ready in ERR1 ignored
    dflt(NSEQ, 4'b1000, 2'd0, "to_addr");
    repeat (16) step(1'b0, IDLE, 4'b0000, 4'b0111, "to_wait", 1, 0, 2'b00, S3, 0, 0, 2'd0, 1, 0);
    step(1'b0, IDLE, 4'b0000, ALL, "to_err1", 1, 0, 2'b01, DEF, 0, 1, 2'd3, 1, 1);
    step(1'b0, IDLE, 4'b0000, ALL, "to_err2", 1, 1, 2'b01, DEF, 0, 0, 2'd3, 1, 1);
    dflt(IDLE, 4'b0000, 2'd3, "to_after");

    // asynchronous reset in the middle of ERR1
    dflt(NSEQ, 4'b0000, 2'd3, "r_addr");
    step(1'b0, IDLE, 4'b0000, ALL, "r_err1", 1, 0, 2'b01, DEF, 1, 0, 2'd3, 1, 0);
    @(negedge Hclk);
    #1;
    Hreset = 1'b1;
    step(1'b1, IDLE, 4'b0000, ALL, "r_reset", 1, 1, 2'b00, DEF, 0, 0, 2'd0, 1, 1);
    dflt(IDLE, 4'b0000, 2'd0, "r_rel");

    // 100-cycle stall: only the watchdog-disabled instance keeps waiting
    dflt(NSEQ, 4'b0001, 2'd0, "z_addr");
    for (int k = 0; k < 100; k++) begin
      step(1'b0, IDLE, 4'b0000, 4'b1110, "z_wait", (k < 16), 0, 2'b00, S0, 0, 0, 2'd0, 1, 0);
    end
    step(1'b0, IDLE, 4'b0000, ALL, "z_done", 0, 1, 2'b00, S0, 0, 0, 2'd0, 1, 1);

    @(negedge Hclk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
